// File: rtl/cache_miss_controller_pkg.sv
// Shared definitions for the cache miss controller: address field sizes,
// default widths and the controller state encoding.
package cache_miss_controller_pkg;

  localparam int TAG_SIZE    = 3;
  localparam int INDEX_SIZE  = 10;
  localparam int OFFSET_SIZE = 2;
  localparam int ADDR_W      = TAG_SIZE + INDEX_SIZE + OFFSET_SIZE;
  localparam int CNT_W       = 14;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COMPARE  = 2'd1,
    MEM_WAIT = 2'd2,
    FILL     = 2'd3
  } state_t;

endpackage

// File: rtl/cache_miss_controller_sat_counter.sv
// Saturating up-counter used for the hit/miss statistics; holds at all-ones.
module sat_counter #(
  parameter int CNT_W = cache_miss_controller_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cache_miss_controller.sv
// Read-miss controller for a direct-mapped cache: compare, block fetch, fill, re-compare.
// Optional hit/miss statistics are built only when CACHE_STATS_EN is defined.
module cache_miss_controller #(
  parameter int ADDR_W = cache_miss_controller_pkg::ADDR_W,
  parameter int CNT_W  = cache_miss_controller_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpuRead,
  input  logic [ADDR_W-1:0] cpuAddr,
  input  logic              cacheHit,
  input  logic              memReady,
  output logic [ADDR_W-1:0] reqAddr,
  output logic              cacheFill,
  output logic              memRead,
  output logic [ADDR_W-3:0] memBlockAddr,
  output logic              cpuReady,
  output logic              busy,
  output logic [CNT_W-1:0]  hitCount,
  output logic [CNT_W-1:0]  missCount
);
  import cache_miss_controller_pkg::*;

  state_t state;

  // All handshake outputs are registered alongside the state, so no input
  // reaches cpuReady, cacheFill or memRead combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      reqAddr   <= '0;
      cpuReady  <= 1'b0;
      cacheFill <= 1'b0;
      memRead   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      cpuReady  <= 1'b0;
      cacheFill <= 1'b0;
      case (state)
        IDLE: begin
          if (cpuRead) begin
            reqAddr <= cpuAddr;
            busy    <= 1'b1;
            state   <= COMPARE;
          end
        end
        COMPARE: begin
          if (cacheHit) begin
            cpuReady <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            memRead <= 1'b1;
            state   <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (memReady) begin
            memRead   <= 1'b0;
            cacheFill <= 1'b1;
            state     <= FILL;
          end
        end
        FILL: begin
          state <= COMPARE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign memBlockAddr = reqAddr[ADDR_W-1:OFFSET_SIZE];

`ifdef CACHE_STATS_EN
  // Only the first compare of a request is counted; a re-compare after a fill is not.
  logic first_cmp;
  logic hit_inc;
  logic miss_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_cmp <= 1'b0;
    end else if ((state == IDLE) && cpuRead) begin
      first_cmp <= 1'b1;
    end else if (state == COMPARE) begin
      first_cmp <= 1'b0;
    end
  end

  assign hit_inc  = (state == COMPARE) && first_cmp && cacheHit;
  assign miss_inc = (state == COMPARE) && first_cmp && !cacheHit;

  sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit_inc),
    .count (hitCount)
  );

  sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (miss_inc),
    .count (missCount)
  );
`else
  assign hitCount  = '0;
  assign missCount = '0;
`endif

endmodule
